// File: rtl/bitserial_pkg.sv
// Shared definitions for the bit-serial gather block.
// Holds the holding-register state encoding and the counter width helper.
package bitserial_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    localparam int N_DEFAULT = 8;
    localparam int CNT_W     = $clog2(N_DEFAULT);

    // Bit-counter width for an arbitrary word length (N >= 2 keeps this >= 1).
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/bitserial_gather_sipo_lane.sv
// One bit-serial lane: an N-bit shift register that takes a new bit at
// bit 0 on every qualified step, so the first bit received ends up at the MSB.
module sipo_lane #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         step,
    input  logic         din,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (step) begin
            q <= {q[N-2:0], din};
        end
    end

endmodule

// File: rtl/bitserial_gather.sv
// Gathers W bit-serial lanes of N-bit MSB-first words into one parallel word
// presented through a single-entry holding register with valid/ready handshake.
module bitserial_gather
    import bitserial_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           step,
    input  logic           sof,
    input  logic [W-1:0]   in,
    output logic [W*N-1:0] out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           overrun,
    input  logic           overrun_clr
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0]  cnt_p0;
    logic [W*N-1:0] lanes_p0;
    logic [W*N-1:0] word_p0;
    logic           done_p0;
    logic [W*N-1:0] hold_p1;
    logic           load;
    logic           drop;
    hold_state_t    state;
    hold_state_t    state_nxt;

    // Stage p0: per-lane shift registers; the completing bit joins the word
    // combinationally so it can be loaded on the same edge it arrives.
    for (genvar gi = 0; gi < W; gi++) begin : g_lane
        sipo_lane #(.N(N)) u_lane (
            .clk  (clk),
            .clr  (clr),
            .step (step),
            .din  (in[gi]),
            .q    (lanes_p0[gi*N +: N])
        );
        assign word_p0[gi*N +: N] = {lanes_p0[gi*N +: N-1], in[gi]};
    end

    // A sof step is always bit 0, so it can never complete a word.
    assign done_p0 = step && !sof && (cnt_p0 == LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_p0 <= '0;
        end else if (step) begin
            if (sof) begin
                cnt_p0 <= CW'(1);
            end else if (cnt_p0 == LAST) begin
                cnt_p0 <= '0;
            end else begin
                cnt_p0 <= cnt_p0 + CW'(1);
            end
        end
    end

    // Stage p1: holding register FSM.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (done_p0) state_nxt = FULL;
            FULL:    if (out_ready && !done_p0) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
        load      = done_p0 && ((state == EMPTY) || out_ready);
        drop      = done_p0 && (state == FULL) && !out_ready;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hold_p1 <= '0;
        end else if (load) begin
            hold_p1 <= word_p0;
        end
    end

    // A new drop outranks a simultaneous clear request.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    assign out = hold_p1;

endmodule

// File: tb/tb_bitserial_gather.sv
// Self-checking bench for bitserial_gather (W=4, N=8): directed scenarios plus
// randomized traffic, checked by a scoreboard fed from a word-level model.
module tb_bitserial_gather;

    localparam int W = 4;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic           step = 1'b0;
    logic           sof = 1'b0;
    logic [W-1:0]   in = '0;
    logic           out_ready = 1'b0;
    logic           overrun_clr = 1'b0;
    logic [W*N-1:0] out;
    logic           out_valid;
    logic           overrun;

    bitserial_gather #(.W(W), .N(N)) dut (
        .clk         (clk),
        .clr         (clr),
        .step        (step),
        .sof         (sof),
        .in          (in),
        .out         (out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: accumulated lane bits, bits since word start, one-slot
    // output buffer, sticky drop flag, and the queue of words the consumer must see.
    logic [W*N-1:0] expq[$];
    logic [N-1:0]   mw[W];
    int             mk    = 0;
    bit             mfull = 1'b0;
    bit             movr  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mk    = 0;
        mfull = 1'b0;
        movr  = 1'b0;
        expq.delete();
        foreach (mw[i]) mw[i] = '0;
    endtask

    task automatic model_edge(input logic st, input logic sf, input logic [W-1:0] b,
                              input logic rdy, input logic oc);
        bit             comp   = 1'b0;
        bit             setovr = 1'b0;
        logic [W*N-1:0] wd     = '0;
        if (mfull && rdy) mfull = 1'b0;
        if (st) begin
            if (sf) mk = 0;
            for (int i = 0; i < W; i++) mw[i] = {mw[i][N-2:0], b[i]};
            mk++;
            if (mk == N) begin
                comp = 1'b1;
                mk   = 0;
            end
        end
        if (comp) begin
            for (int i = 0; i < W; i++) wd[i*N +: N] = mw[i];
            if (!mfull) begin
                expq.push_back(wd);
                mfull = 1'b1;
            end else begin
                setovr = 1'b1;
            end
        end
        if (oc) movr = 1'b0;
        if (setovr) movr = 1'b1;
    endtask

    // Inputs change 1 time unit after the rising edge; the model then advances.
    task automatic cyc(input logic st, input logic sf, input logic [W-1:0] b,
                       input logic rdy, input logic oc);
        step        = st;
        sof         = sf;
        in          = b;
        out_ready   = rdy;
        overrun_clr = oc;
        @(posedge clk);
        #1;
        model_edge(st, sf, b, rdy, oc);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 4'($urandom), rdy, 1'b0);
    endtask

    task automatic send_word(input logic [W*N-1:0] w, input bit sof0, input bit gap,
                             input logic rdy, input logic rdy_last, input logic oc_last);
        logic [W-1:0] b;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < W; i++) b[i] = w[i*N + N-1-j];
            cyc(1'b1, sof0 && (j == 0), b, (j == N-1) ? rdy_last : rdy,
                (j == N-1) ? oc_last : 1'b0);
            if (gap && j < N-1) idle(rdy);
        end
    endtask

    task automatic do_reset(input int cycles);
        clr = 1'b1;
        model_reset();
        for (int k = 0; k < cycles; k++) begin
            step        = 1'($urandom);
            sof         = 1'($urandom);
            in          = 4'($urandom);
            out_ready   = 1'($urandom);
            overrun_clr = 1'($urandom);
            @(negedge clk);
            check("clr_out", out, 32'h0);
            check("clr_valid", 32'(out_valid), 32'h0);
            check("clr_overrun", 32'(overrun), 32'h0);
            @(posedge clk);
            #1;
        end
        clr         = 1'b0;
        step        = 1'b0;
        sof         = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
    endtask

    // Monitor: compares the DUT against the model away from the active edge and
    // retires a word from the scoreboard whenever a handshake is about to occur.
    always @(negedge clk) begin
        if (!clr) begin
            check("out_valid", 32'(out_valid), 32'(mfull));
            check("overrun", 32'(overrun), 32'(movr));
            if (mfull) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard: got word %h, expected none queued", out);
                end else begin
                    check("out_word", out, expq[0]);
                    if (out_ready) void'(expq.pop_front());
                end
            end
        end
    end

    logic [W*N-1:0] wa;
    logic [W*N-1:0] wb;

    initial begin
        do_reset(3);

        // Basic gather with sof on the first step.
        send_word(32'h01FF3CA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("basic_valid", 32'(out_valid), 32'h1);
        check("basic_out", out, 32'h01FF3CA5);
        idle(1'b1);
        check("basic_pulse", 32'(out_valid), 32'h0);

        // Gapped steps give the same word.
        send_word(32'h01FF3CA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("gap_out", out, 32'h01FF3CA5);
        idle(1'b1);
        check("gap_pulse", 32'(out_valid), 32'h0);

        // Backpressure: A is held, B is dropped, overrun latches.
        wa = 32'h11223344;
        wb = $urandom;
        send_word(wa, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_a", out, wa);
        send_word(wb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_hold", out, wa);
        check("bp_overrun", 32'(overrun), 32'h1);
        idle(1'b1);
        check("bp_accept", 32'(out_valid), 32'h0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("bp_ovr_clr", 32'(overrun), 32'h0);

        // Clear and a fresh drop in the same cycle: the drop wins.
        send_word($urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word($urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("set_wins", 32'(overrun), 32'h1);
        idle(1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Back-to-back words at full rate, then a completion coinciding with an accept.
        for (int k = 0; k < 3; k++) send_word($urandom, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("b2b_overrun", 32'(overrun), 32'h0);
        wa = $urandom;
        send_word(wa, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_keep_valid", 32'(out_valid), 32'h1);
        check("b2b_new_word", out, wa);
        check("b2b_no_ovr", 32'(overrun), 32'h0);
        idle(1'b1);

        // Resync: 3 stray bits, then sof restarts the word.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 4'($urandom), 1'b1, 1'b0);
        wa = $urandom;
        send_word(wa, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("resync_out", out, wa);
        idle(1'b1);

        // Reset mid-word: the next step is bit 0 without sof.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 4'($urandom), 1'b1, 1'b0);
        do_reset(2);
        wa = $urandom;
        send_word(wa, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_resume", out, wa);
        idle(1'b1);

        // Randomized traffic with occasional sof, stalls and clears.
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) do_reset(2);
            cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 29) == 0), 4'($urandom),
                1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end
        for (int k = 0; k < 3; k++) idle(1'b1);
        check("drained", 32'(expq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
